// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module   : universal_shift_register
// Brief    : Parametrised shift/rotate/load/clear register with multi-step
//            bursts (one step per clock) and busy/done handshaking.
// Revision : 1.0 - initial release
// ============================================================================
module universal_shift_register #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       M,
  input  logic [AMT_W-1:0] amt,
  input  logic             SI,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             so_lsb,
  output logic             so_msb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] c_M_HOLD = 3'b000;
  localparam logic [2:0] c_M_SHR  = 3'b001;
  localparam logic [2:0] c_M_SHL  = 3'b010;
  localparam logic [2:0] c_M_LOAD = 3'b011;
  localparam logic [2:0] c_M_ROR  = 3'b100;
  localparam logic [2:0] c_M_ROL  = 3'b101;
  localparam logic [2:0] c_M_ASR  = 3'b110;
  localparam logic [2:0] c_M_CLR  = 3'b111;

  localparam logic [0:0] c_S_IDLE = 1'b0;
  localparam logic [0:0] c_S_RUN  = 1'b1;

  localparam logic [AMT_W-1:0] c_AMT_ONE   = AMT_W'(1);
  localparam logic [AMT_W-1:0] c_AMT_WIDTH = AMT_W'(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             w_accept;
  logic             w_multi_mode;
  logic [AMT_W-1:0] w_n;
  logic [2:0]       w_step_mode;
  logic             w_step;

  // Only the shift/rotate family honours amt; other modes are single-step.
  always_comb begin
    w_multi_mode = (M == c_M_SHR) || (M == c_M_SHL) || (M == c_M_ROR) ||
                   (M == c_M_ROL) || (M == c_M_ASR);
    if (!w_multi_mode || (amt == '0)) begin
      w_n = c_AMT_ONE;
    end else if (amt > c_AMT_WIDTH) begin
      w_n = c_AMT_WIDTH;
    end else begin
      w_n = amt;
    end
  end

  assign w_accept    = en && !busy_q;
  assign w_step      = (state_q == c_S_RUN) || w_accept;
  assign w_step_mode = (state_q == c_S_RUN) ? mode_q : M;

  function automatic logic [WIDTH-1:0] f_step(input logic [2:0]       mode,
                                               input logic [WIDTH-1:0] cur,
                                               input logic             si,
                                               input logic [WIDTH-1:0] din);
    logic [WIDTH-1:0] res;
    res = cur;
    case (mode)
      c_M_HOLD: res = cur;
      c_M_SHR:  res = {si, cur[WIDTH-1:1]};
      c_M_SHL:  res = {cur[WIDTH-2:0], si};
      c_M_LOAD: res = din;
      c_M_ROR:  res = {cur[0], cur[WIDTH-1:1]};
      c_M_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      c_M_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      c_M_CLR:  res = '0;
      default:  res = cur;
    endcase
    return res;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_S_IDLE;
      mode_q  <= c_M_HOLD;
      rem_q   <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: rem_q counts steps still owed after the current edge.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    case (state_q)
      c_S_IDLE: begin
        if (w_accept) begin
          mode_d = M;
          if (w_n != c_AMT_ONE) begin
            rem_d   = w_n - c_AMT_ONE;
            state_d = c_S_RUN;
          end else begin
            rem_d = '0;
          end
        end
      end
      c_S_RUN: begin
        rem_d = rem_q - c_AMT_ONE;
        if (rem_q == c_AMT_ONE) begin
          state_d = c_S_IDLE;
        end
      end
      default: begin
        state_d = c_S_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Output/datapath logic
  always_comb begin
    q_d    = q_q;
    busy_d = (state_d == c_S_RUN);
    done_d = 1'b0;
    if (w_step) begin
      q_d = f_step(w_step_mode, q_q, SI, D);
    end
    if (state_q == c_S_RUN) begin
      done_d = (rem_q == c_AMT_ONE);
    end else if (w_accept) begin
      done_d = (w_n == c_AMT_ONE);
    end
  end

  assign Q      = q_q;
  assign so_lsb = q_q[0];
  assign so_msb = q_q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// Bench for universal_shift_register: behavioural model compared every cycle
// plus hand-computed expectations along the directed scenarios.
module tb_universal_shift_register;

  localparam int W  = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset, en, SI;
  logic [2:0]    M;
  logic [AW-1:0] amt;
  logic [W-1:0]  D;
  logic [W-1:0]  Q;
  logic          so_lsb, so_msb, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  universal_shift_register #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .reset(reset), .en(en), .M(M), .amt(amt), .SI(SI), .D(D),
    .Q(Q), .so_lsb(so_lsb), .so_msb(so_msb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mq;
  logic [2:0]  mmode;
  int          mleft = 0;
  logic        mdone = 1'b0;
  logic        mvalid = 1'b0;

  function automatic logic [31:0] mstep(input logic [2:0] mode, input logic [31:0] cur,
                                        input logic si, input logic [31:0] din);
    logic [31:0] msk;
    msk = (32'd1 << W) - 32'd1;
    case (mode)
      3'd1:    return (cur >> 1) | (32'(si) << (W - 1));
      3'd2:    return ((cur << 1) | 32'(si)) & msk;
      3'd3:    return din & msk;
      3'd4:    return (cur >> 1) | ((cur & 32'd1) << (W - 1));
      3'd5:    return ((cur << 1) & msk) | (cur >> (W - 1));
      3'd6:    return (cur >> 1) | (cur & (32'd1 << (W - 1)));
      3'd7:    return 32'd0;
      default: return cur;
    endcase
  endfunction

  always @(posedge clk) begin
    int n;
    if (reset) begin
      mq = 0; mleft = 0; mdone = 1'b0; mvalid = 1'b1;
    end else begin
      mdone = 1'b0;
      if (mleft > 0) begin
        mq = mstep(mmode, mq, SI, 32'(D));
        mleft--;
        if (mleft == 0) mdone = 1'b1;
      end else if (en) begin
        if (M inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})
          n = (amt == 0) ? 1 : ((int'(amt) > W) ? W : int'(amt));
        else
          n = 1;
        mmode = M;
        mq = mstep(M, mq, SI, 32'(D));
        mleft = n - 1;
        if (mleft == 0) mdone = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_Q", 32'(Q), mq);
      chk("model_so_lsb", 32'(so_lsb), mq & 32'd1);
      chk("model_so_msb", 32'(so_msb), (mq >> (W - 1)) & 32'd1);
      chk("model_busy", 32'(busy), 32'(mleft > 0));
      chk("model_done", 32'(done), 32'(mdone));
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic req(input logic [2:0] m, input logic [AW-1:0] a, input logic si,
                     input logic [W-1:0] d);
    en = 1'b1; M = m; amt = a; SI = si; D = d;
    cyc();
    en = 1'b0;
  endtask

  initial begin
    int d0;
    reset = 1'b1; en = 1'b0; M = 3'd0; amt = '0; SI = 1'b0; D = '0;
    repeat (2) cyc();
    chk("rst_Q", 32'(Q), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_so", 32'({so_msb, so_lsb}), 32'h0);
    reset = 1'b0;
    cyc();

    // load
    req(3'b011, 3'd0, 1'b0, 4'b1011);
    chk("load_Q", 32'(Q), 32'b1011);
    chk("load_done", 32'(done), 32'h1);
    chk("load_busy", 32'(busy), 32'h0);
    cyc();
    chk("load_done_clr", 32'(done), 32'h0);

    // rotate right by 2
    req(3'b100, 3'd2, 1'b0, 4'b0000);
    chk("ror_Q1", 32'(Q), 32'b1101);
    chk("ror_busy1", 32'(busy), 32'h1);
    chk("ror_done1", 32'(done), 32'h0);
    cyc();
    chk("ror_Q2", 32'(Q), 32'b1110);
    chk("ror_busy2", 32'(busy), 32'h0);
    chk("ror_done2", 32'(done), 32'h1);

    // arithmetic shift right by 3
    req(3'b011, 3'd0, 1'b0, 4'b1000);
    req(3'b110, 3'd3, 1'b0, 4'b0000);
    chk("asr_Q1", 32'(Q), 32'b1100);
    cyc();
    chk("asr_Q2", 32'(Q), 32'b1110);
    cyc();
    chk("asr_Q3", 32'(Q), 32'b1111);
    chk("asr_done", 32'(done), 32'h1);

    // shift left with amt clamped 7 -> 4
    req(3'b111, 3'd0, 1'b0, 4'b0000);
    chk("clr_Q", 32'(Q), 32'h0);
    req(3'b010, 3'd7, 1'b1, 4'b0000);
    chk("shl_Q1", 32'(Q), 32'b0001);
    chk("shl_busy", 32'(busy), 32'h1);
    repeat (2) cyc();
    chk("shl_done_early", 32'(done), 32'h0);
    cyc();
    chk("shl_Q4", 32'(Q), 32'b1111);
    chk("shl_done", 32'(done), 32'h1);
    cyc();
    chk("shl_no_5th", 32'(Q), 32'b1111);

    // request while busy is ignored
    req(3'b011, 3'd0, 1'b0, 4'b0110);
    req(3'b101, 3'd4, 1'b0, 4'b0000);
    d0 = done_cnt;
    chk("rol_Q1", 32'(Q), 32'b1100);
    req(3'b111, 3'd0, 1'b0, 4'b0000);
    chk("ign_Q2", 32'(Q), 32'b1001);
    cyc();
    chk("ign_Q3", 32'(Q), 32'b0011);
    cyc();
    chk("ign_Q4", 32'(Q), 32'b0110);
    repeat (2) cyc();
    chk("ign_done_count", 32'(done_cnt - d0), 32'd1);

    // reset mid-burst
    req(3'b011, 3'd0, 1'b0, 4'b0011);
    req(3'b100, 3'd4, 1'b0, 4'b0000);
    chk("mid_Q1", 32'(Q), 32'b1001);
    d0 = done_cnt;
    reset = 1'b1;
    cyc();
    chk("mid_rst_Q", 32'(Q), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    repeat (4) cyc();
    chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
    req(3'b011, 3'd0, 1'b0, 4'b0101);
    chk("mid_load_Q", 32'(Q), 32'b0101);

    // hold still completes
    cyc();
    req(3'b000, 3'd5, 1'b1, 4'b1111);
    chk("hold_Q", 32'(Q), 32'b0101);
    chk("hold_done", 32'(done), 32'h1);

    // shift right amt=0 -> one step; then burst with live SI
    req(3'b001, 3'd0, 1'b1, 4'b0000);
    chk("shr1_Q", 32'(Q), 32'b1010);
    chk("shr1_busy", 32'(busy), 32'h0);
    req(3'b001, 3'd4, 1'b1, 4'b0000);
    chk("shr_live_Q1", 32'(Q), 32'b1101);
    SI = 1'b0; cyc();
    SI = 1'b1; cyc();
    SI = 1'b0; cyc();
    chk("shr_live_Q4", 32'(Q), 32'b0101);
    chk("shr_live_done", 32'(done), 32'h1);

    // back-to-back rotate lefts, en held through done cycle
    en = 1'b1; M = 3'b101; amt = 3'd2;
    repeat (6) cyc();
    en = 1'b0;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
